// File: rtl/uart_word_receiver.sv
// UART receive side of the 32-bit word link: 16x oversampled 8N2 frames,
// reassembled LSB byte first into 32-bit words with a partial-word timeout.
module uart_word_receiver #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVS          = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD,
    output logic [31:0] dataOut,
    output logic        dataOver,
    output logic        frameError
);
    localparam int DIV  = CLK_FREQ / (BAUD * OVS);
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW   = $clog2(OVS);
    localparam int TO   = TIMEOUT_BITS * OVS;
    localparam int TW   = $clog2(TO + 1);
    localparam int HALF = OVS / 2 - 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP1, STOP2, BRK
    } state_t;

    state_t state, state_n;

    logic          rx_meta, rxs;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [SW-1:0] sc;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [1:0]    bc;
    logic [31:0]   asm_q;
    logic [TW-1:0] to_cnt;

    logic sc_clr, sc_inc, div_clr, sample, accept, ferr;
    logic sc_half, sc_last, to_run, to_hit;

    assign tick    = (div_cnt == DW'(DIV - 1));
    assign sc_half = (sc == SW'(HALF));
    assign sc_last = (sc == SW'(OVS - 1));
    assign to_run  = (state == IDLE) && rxs && (bc != 2'd0);
    assign to_hit  = to_run && tick && (to_cnt == TW'(TO - 1));

    always_comb begin
        state_n = state;
        sc_clr  = 1'b0;
        sc_inc  = 1'b0;
        div_clr = 1'b0;
        sample  = 1'b0;
        accept  = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    sc_clr  = 1'b1;
                    div_clr = 1'b1;
                end
            end
            START: begin
                if (tick && sc_half) begin
                    sc_clr  = 1'b1;
                    state_n = rxs ? IDLE : DATA;
                end else if (tick) begin
                    sc_inc = 1'b1;
                end
            end
            DATA: begin
                if (tick && sc_last) begin
                    sc_clr = 1'b1;
                    sample = 1'b1;
                    if (bit_cnt == 3'd7) state_n = STOP1;
                end else if (tick) begin
                    sc_inc = 1'b1;
                end
            end
            STOP1, STOP2: begin
                if (tick && sc_last) begin
                    sc_clr = 1'b1;
                    if (!rxs) begin
                        ferr    = 1'b1;
                        state_n = BRK;
                    end else if (state == STOP1) begin
                        state_n = STOP2;
                    end else begin
                        accept  = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tick) begin
                    sc_inc = 1'b1;
                end
            end
            BRK: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            div_cnt    <= '0;
            sc         <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            bc         <= '0;
            asm_q      <= '0;
            to_cnt     <= '0;
            dataOut    <= '0;
            dataOver   <= 1'b0;
            frameError <= 1'b0;
        end else begin
            rx_meta    <= RxD;
            rxs        <= rx_meta;
            dataOver   <= 1'b0;
            frameError <= ferr;

            if (div_clr || tick) div_cnt <= '0;
            else                 div_cnt <= div_cnt + 1'b1;

            if (sc_clr)      sc <= '0;
            else if (sc_inc) sc <= sc + 1'b1;

            if (sample) begin
                shreg   <= {rxs, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Timeout only advances while idling on a partial word
            if (!to_run || to_hit) to_cnt <= '0;
            else if (tick)         to_cnt <= to_cnt + 1'b1;

            if (ferr || to_hit) begin
                bc <= '0;
            end else if (accept) begin
                asm_q[{bc, 3'b000} +: 8] <= shreg;
                bc <= bc + 2'd1;
                if (bc == 2'd3) begin
                    dataOut  <= {shreg, asm_q[23:0]};
                    dataOver <= 1'b1;
                end
            end
        end
    end
endmodule
